// File: rtl/ram_sp_clr.sv
// Single-port RAM with a self-timed clear sweep that writes CLEAR_VALUE to every
// word; the sweep also runs after reset, since the array itself is never reset.
module ram_sp_clr #(
  parameter int                WIDTH       = 8,
  parameter int                ADDR_WIDTH  = 4,
  parameter int                READ_MODE   = 0,
  parameter logic [WIDTH-1:0]  CLEAR_VALUE = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  write_en,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic [WIDTH-1:0]      data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   clr_ptr, next_ptr;
  logic                    next_done;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]        mem_data;
  logic [WIDTH-1:0]        ram [DEPTH];

  // Reset lands in CLEAR so the first clock after release starts the sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= next_state;
      clr_ptr    <= next_ptr;
      clear_done <= next_done;
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = clr_ptr;
    next_done  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = address;
    mem_data   = data_in;
    case (state)
      IDLE: begin
        // A clear request wins over a user write on the same edge.
        if (clear_req) begin
          next_state = CLEAR;
          next_ptr   = '0;
        end else if (write_en) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_ptr;
        mem_data = CLEAR_VALUE;
        next_ptr = clr_ptr + 1'b1;
        if (clr_ptr == LAST_ADDR) begin
          next_state = IDLE;
          next_done  = 1'b1;
        end
      end
      default: begin
        next_state = CLEAR;
        next_ptr   = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // Array has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      ram[mem_addr] <= mem_data;
    end
  end

  generate
    if (READ_MODE == 1) begin : g_reg_read
      logic [WIDTH-1:0] rd_q;

      // Read-first: the register samples the array before this edge's write lands.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_q <= CLEAR_VALUE;
        end else if (state == CLEAR) begin
          rd_q <= CLEAR_VALUE;
        end else begin
          rd_q <= ram[address];
        end
      end

      assign data_out = busy ? CLEAR_VALUE : rd_q;
    end else begin : g_async_read
      assign data_out = busy ? CLEAR_VALUE : ram[address];
    end
  endgenerate

endmodule
